dcache_ctrl: RTL and testbench

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_ctrl.sv | 154 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back data cache controller with 256-bit lines.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
`default_nettype none

module dcache_ctrl #(
    parameter int LINES = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  p1_addr_i,
    input  logic [31:0]  p1_data_i,
    input  logic         p1_MemRead_i,
    input  logic         p1_MemWrite_i,
    output logic [31:0]  p1_data_o,
    output logic         p1_stall_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,
    output logic [255:0] mem_data_o,
    output logic [31:0]  mem_addr_o,
    output logic         mem_enable_o,
    output logic         mem_write_o
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 27 - IDX_W;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] ALLOCATE  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [LINES-1:0] valid;
    logic [LINES-1:0] dirty;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [255:0]     data_mem [LINES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [2:0]       word;
    logic [TAG_W-1:0] victim_tag;
    logic [255:0]     line;
    logic [31:0]      sel_word;
    logic             req;
    logic             is_write;
    logic             hit;
    logic             miss;
    logic             unused_addr;

    assign idx         = p1_addr_i[5 +: IDX_W];
    assign tag         = p1_addr_i[31 -: TAG_W];
    assign word        = p1_addr_i[4:2];
    assign unused_addr = ^p1_addr_i[1:0];
    assign victim_tag  = tag_mem[idx];
    assign line        = data_mem[idx];
    assign sel_word    = line[{word, 5'b0} +: 32];

    // A simultaneous read+write request is handled as a store.
    assign req      = p1_MemRead_i | p1_MemWrite_i;
    assign is_write = p1_MemWrite_i;
    assign hit      = (state == IDLE) && req && valid[idx] && (tag_mem[idx] == tag);
    assign miss     = (state == IDLE) && req && !hit;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (miss) begin
                    state_nxt = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: if (mem_ack_i) state_nxt = ALLOCATE;
            ALLOCATE:  if (mem_ack_i) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= state_nxt;
            if (hit && is_write) begin
                dirty[idx] <= 1'b1;
            end
            if ((state == ALLOCATE) && mem_ack_i) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if ((state == ALLOCATE) && mem_ack_i) begin
            data_mem[idx] <= mem_data_i;
            tag_mem[idx]  <= tag;
        end else if (hit && is_write) begin
            data_mem[idx][{word, 5'b0} +: 32] <= p1_data_i;
        end
    end

    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state)
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {victim_tag, idx, 5'b0};
                mem_data_o   = line;
            end
            ALLOCATE: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {tag, idx, 5'b0};
            end
            default: ;
        endcase
    end

    assign p1_data_o  = (hit && !is_write) ? sel_word : 32'd0;
    // Stall is forced low while reset is asserted, even if a request is held.
    assign p1_stall_o = rst & ((req & ~hit) | (state != IDLE));

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit)  hit_cnt  <= hit_cnt + 32'd1;
            if (miss) miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt;
    assign miss_cnt_o = miss_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl with a simple memory responder.
`default_nettype none

module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  p1_addr_i = '0;
    logic [31:0]  p1_data_i = '0;
    logic         p1_MemRead_i = 1'b0;
    logic         p1_MemWrite_i = 1'b0;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;
    logic [255:0] mem_data_o;
    logic [31:0]  mem_addr_o;
    logic         mem_enable_o;
    logic         mem_write_o;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;
    logic [31:0]  hit_before;
`endif

    typedef struct packed {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } mem_t;

    mem_t        exp_mem[$];
    logic [31:0] exp_rd[$];
    int          checks = 0;
    int          errors = 0;
    bit          resp_en = 1'b1;
    int          stalls;

    dcache_ctrl #(.LINES(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .p1_addr_i    (p1_addr_i),
        .p1_data_i    (p1_data_i),
        .p1_MemRead_i (p1_MemRead_i),
        .p1_MemWrite_i(p1_MemWrite_i),
        .p1_data_o    (p1_data_o),
        .p1_stall_o   (p1_stall_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i),
        .mem_data_o   (mem_data_o),
        .mem_addr_o   (mem_addr_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Memory contents: word i of the line at address A is (A<<2)+i.
    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = (a << 2) + i;
        return l;
    endfunction

    initial begin : responder
        forever begin
            @(negedge clk);
            if (resp_en && mem_enable_o) begin
                @(posedge clk);
                #1;
                mem_data_i = line_of(mem_addr_o);
                mem_ack_i  = 1'b1;
                @(posedge clk);
                #1;
                mem_ack_i  = 1'b0;
            end
        end
    end

    initial begin : monitor
        mem_t e;
        logic [31:0] r;
        forever begin
            @(negedge clk);
            if (mem_enable_o && mem_ack_i) begin
                if (exp_mem.size() == 0) begin
                    chk("unexpected_mem_txn", {223'd0, mem_write_o, mem_addr_o}, '1);
                end else begin
                    e = exp_mem.pop_front();
                    chk("mem_write", {255'd0, mem_write_o}, {255'd0, e.wr});
                    chk("mem_addr", {224'd0, mem_addr_o}, {224'd0, e.addr});
                    chk("mem_data", mem_data_o, e.data);
                end
            end
            if (rst && p1_MemRead_i && !p1_MemWrite_i && !p1_stall_o) begin
                if (exp_rd.size() == 0) begin
                    chk("unexpected_load", {224'd0, p1_data_o}, '1);
                end else begin
                    r = exp_rd.pop_front();
                    chk("load_data", {224'd0, p1_data_o}, {224'd0, r});
                end
            end
        end
    end

    task automatic do_read(input logic [31:0] a);
        int n;
        p1_addr_i = a;
        p1_MemRead_i = 1'b1;
        p1_MemWrite_i = 1'b0;
        stalls = 0;
        n = 0;
        @(negedge clk);
        while (p1_stall_o && n < 200) begin
            stalls++;
            n++;
            @(negedge clk);
        end
        if (n >= 200) chk("read_timeout", 256'd1, 256'd0);
        @(posedge clk);
        #1;
        p1_MemRead_i = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic both);
        p1_addr_i = a;
        p1_data_i = d;
        p1_MemWrite_i = 1'b1;
        p1_MemRead_i = both;
        @(negedge clk);
        chk("store_hit_stall", {255'd0, p1_stall_o}, 256'd0);
        @(posedge clk);
        #1;
        p1_MemWrite_i = 1'b0;
        p1_MemRead_i = 1'b0;
    endtask

    initial begin : stim
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", {255'd0, p1_stall_o}, 256'd0);
        chk("rst_mem_en", {255'd0, mem_enable_o}, 256'd0);
        chk("rst_mem_wr", {255'd0, mem_write_o}, 256'd0);
        chk("rst_mem_addr", {224'd0, mem_addr_o}, 256'd0);
        chk("rst_p1_data", {224'd0, p1_data_o}, 256'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Cold miss: one refill of line 0x40.
        exp_mem.push_back('{wr: 1'b0, addr: 32'h40, data: 256'd0});
        exp_rd.push_back(32'h100);
        do_read(32'h40);
        chk("alloc_stalled", {255'd0, stalls != 0}, 256'd1);

        do_write(32'h44, 32'hDEADBEEF, 1'b0);
        exp_rd.push_back(32'hDEADBEEF);
        do_read(32'h44);
        chk("hit_no_stall", stalls, 256'd0);

`ifdef DCACHE_STATS_EN
        hit_before = hit_cnt_o;
`endif
        do_write(32'h48, 32'h12345678, 1'b1);
`ifdef DCACHE_STATS_EN
        chk("hit_cnt_inc", {224'd0, hit_cnt_o - hit_before}, 256'd1);
`endif
        exp_rd.push_back(32'h12345678);
        do_read(32'h48);

        // Conflict miss on a dirty line: write-back then refill.
        exp_mem.push_back('{wr: 1'b1, addr: 32'h40,
            data: {32'h107, 32'h106, 32'h105, 32'h104, 32'h103,
                   32'h12345678, 32'hDEADBEEF, 32'h100}});
        exp_mem.push_back('{wr: 1'b0, addr: 32'h440, data: 256'd0});
        exp_rd.push_back(32'h1100);
        do_read(32'h440);
        exp_rd.push_back(32'h1107);
        do_read(32'h45C);

        // Reset in the middle of a refill whose ack arrives late.
        resp_en = 1'b0;
        p1_addr_i = 32'h40;
        p1_MemRead_i = 1'b1;
        n = 0;
        @(negedge clk);
        while (!mem_enable_o && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("alloc_started", {255'd0, mem_enable_o}, 256'd1);
        chk("alloc_mem_wr", {255'd0, mem_write_o}, 256'd0);
        chk("alloc_addr", {224'd0, mem_addr_o}, {224'd0, 32'h40});
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_mem_en", {255'd0, mem_enable_o}, 256'd0);
        chk("midrst_stall", {255'd0, p1_stall_o}, 256'd0);
        p1_MemRead_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_data_i = {8{32'hBADBAD00}};
        mem_ack_i = 1'b1;
        @(posedge clk);
        #1;
        mem_ack_i = 1'b0;
        @(negedge clk);
        chk("late_ack_mem_en", {255'd0, mem_enable_o}, 256'd0);
        chk("late_ack_stall", {255'd0, p1_stall_o}, 256'd0);
        resp_en = 1'b1;
        @(posedge clk);
        #1;
        exp_mem.push_back('{wr: 1'b0, addr: 32'h40, data: 256'd0});
        exp_rd.push_back(32'h100);
        do_read(32'h40);
        chk("remiss_stalled", {255'd0, stalls != 0}, 256'd1);

        repeat (4) @(posedge clk);
        #1;
        chk("exp_mem_drained", exp_mem.size(), 256'd0);
        chk("exp_rd_drained", exp_rd.size(), 256'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
